// File: rtl/nabp_swap_control.sv
// Sweep sequencer: hands out projection angles to two banks and arbitrates the shared shifter.
// Outputs are registered one cycle after their cause; no backpressure, banks must hold requests/levels themselves.
module nabp_swap_control #(
    parameter int ANGLE_LEN  = 8,
    parameter int NUM_ANGLES = 180,
    parameter int ANGLE_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 sc_reset_n,
    input  logic                 next_angle_0,
    input  logic                 next_angle_1,
    input  logic                 fill_waiting_0,
    input  logic                 fill_waiting_1,
    input  logic                 shift_done_0,
    input  logic                 shift_done_1,
    output logic [ANGLE_LEN-1:0] angle_0,
    output logic [ANGLE_LEN-1:0] angle_1,
    output logic                 angle_valid_0,
    output logic                 angle_valid_1,
    output logic                 swap_0,
    output logic                 swap_1
);

    localparam int KW  = $clog2(NUM_ANGLES + 1);
    localparam int KW1 = KW + 1;
    localparam logic [KW:0]          N_X    = KW1'(NUM_ANGLES);
    localparam logic [KW-1:0]        N_LAST = KW'(NUM_ANGLES - 1);
    localparam logic [ANGLE_LEN-1:0] STEP_L = ANGLE_LEN'(ANGLE_STEP);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_t;

    state_t               r_state;
    owner_t               r_owner;
    logic                 r_last_1;
    logic [KW-1:0]        r_k;
    logic [KW-1:0]        r_completed;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sc_reset_n;
    logic [ANGLE_LEN-1:0] r_angle_0;
    logic [ANGLE_LEN-1:0] r_angle_1;
    logic                 r_angle_valid_0;
    logic                 r_angle_valid_1;
    logic                 r_swap_0;
    logic                 r_swap_1;

    logic [KW:0]          w_idx0;
    logic [KW:0]          w_idx1;
    logic                 w_grant0;
    logic                 w_grant1;
    logic [ANGLE_LEN-1:0] w_ang0;
    logic [ANGLE_LEN-1:0] w_ang1;
    logic [KW-1:0]        w_k_next;
    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_pick0;
    logic                 w_pick1;
    logic                 w_sd_own;
    logic                 w_last;

    // Simultaneous requests: bank 0 takes index k, bank 1 the one after it.
    assign w_idx0   = {1'b0, r_k};
    assign w_idx1   = next_angle_0 ? (w_idx0 + KW1'(1)) : w_idx0;
    assign w_grant0 = next_angle_0 && (w_idx0 < N_X);
    assign w_grant1 = next_angle_1 && (w_idx1 < N_X);
    assign w_ang0   = ANGLE_LEN'(w_idx0) * STEP_L;
    assign w_ang1   = ANGLE_LEN'(w_idx1) * STEP_L;
    assign w_k_next = r_k + KW'(w_grant0) + KW'(w_grant1);

    assign w_elig0  = (r_owner == OWN_NONE) && fill_waiting_0 && r_angle_valid_0;
    assign w_elig1  = (r_owner == OWN_NONE) && fill_waiting_1 && r_angle_valid_1;
    // r_last_1 starts set after start so bank 0 wins the first tie.
    assign w_pick1  = w_elig1 && (!w_elig0 || !r_last_1);
    assign w_pick0  = w_elig0 && !w_pick1;
    assign w_sd_own = ((r_owner == OWN_0) && shift_done_0) || ((r_owner == OWN_1) && shift_done_1);
    assign w_last   = w_sd_own && (r_completed == N_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_owner         <= OWN_NONE;
            r_last_1        <= 1'b1;
            r_k             <= '0;
            r_completed     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_sc_reset_n    <= 1'b0;
            r_angle_0       <= '0;
            r_angle_1       <= '0;
            r_angle_valid_0 <= 1'b0;
            r_angle_valid_1 <= 1'b0;
            r_swap_0        <= 1'b0;
            r_swap_1        <= 1'b0;
        end else begin
            r_swap_0 <= 1'b0;
            r_swap_1 <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state         <= S_RUN;
                        r_busy          <= 1'b1;
                        r_sc_reset_n    <= 1'b1;
                        r_k             <= '0;
                        r_completed     <= '0;
                        r_owner         <= OWN_NONE;
                        r_last_1        <= 1'b1;
                        r_angle_0       <= '0;
                        r_angle_1       <= '0;
                        r_angle_valid_0 <= 1'b0;
                        r_angle_valid_1 <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (next_angle_0) begin
                        r_angle_0       <= w_grant0 ? w_ang0 : '0;
                        r_angle_valid_0 <= w_grant0;
                    end
                    if (next_angle_1) begin
                        r_angle_1       <= w_grant1 ? w_ang1 : '0;
                        r_angle_valid_1 <= w_grant1;
                    end
                    r_k <= w_k_next;
                    if (w_pick0) begin
                        r_swap_0 <= 1'b1;
                        r_owner  <= OWN_0;
                        r_last_1 <= 1'b0;
                    end else if (w_pick1) begin
                        r_swap_1 <= 1'b1;
                        r_owner  <= OWN_1;
                        r_last_1 <= 1'b1;
                    end else if (w_sd_own) begin
                        r_owner     <= OWN_NONE;
                        r_completed <= r_completed + KW'(1);
                    end
                    if (w_last) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_sc_reset_n <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign sc_reset_n    = r_sc_reset_n;
    assign angle_0       = r_angle_0;
    assign angle_1       = r_angle_1;
    assign angle_valid_0 = r_angle_valid_0;
    assign angle_valid_1 = r_angle_valid_1;
    assign swap_0        = r_swap_0;
    assign swap_1        = r_swap_1;

endmodule

// File: tb/tb_nabp_swap_control.sv
// Bench for nabp_swap_control: three instances (3x60, 4x100 wrap, 1x1) checked every cycle
// against a ticket-dispenser/owner model, plus hand-computed literal expectations.
module tb_nabp_swap_control;

    localparam int NI = 3;

    function automatic int n_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 4 : 1);
    endfunction

    function automatic int s_of(input int i);
        return (i == 0) ? 60 : ((i == 1) ? 100 : 1);
    endfunction

    logic clk = 1'b0;
    logic reset_n;
    logic st [NI];
    logic na0 [NI];
    logic na1 [NI];
    logic fw0 [NI];
    logic fw1 [NI];
    logic sd0 [NI];
    logic sd1 [NI];
    logic busy [NI];
    logic done [NI];
    logic scr [NI];
    logic sw0 [NI];
    logic sw1 [NI];
    logic av0 [NI];
    logic av1 [NI];
    logic [7:0] an0 [NI];
    logic [7:0] an1 [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        nabp_swap_control #(
            .ANGLE_LEN (8),
            .NUM_ANGLES(n_of(g)),
            .ANGLE_STEP(s_of(g))
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .start         (st[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .sc_reset_n    (scr[g]),
            .next_angle_0  (na0[g]),
            .next_angle_1  (na1[g]),
            .fill_waiting_0(fw0[g]),
            .fill_waiting_1(fw1[g]),
            .shift_done_0  (sd0[g]),
            .shift_done_1  (sd1[g]),
            .angle_0       (an0[g]),
            .angle_1       (an1[g]),
            .angle_valid_0 (av0[g]),
            .angle_valid_1 (av1[g]),
            .swap_0        (sw0[g]),
            .swap_1        (sw1[g])
        );
    end

    int n_tot  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model: busy/done flags, a ticket counter of issued angles, shifter owner (-1 none) and tie preference.
    int m_busy [NI];
    int m_done [NI];
    int m_sw0 [NI];
    int m_sw1 [NI];
    int m_v0 [NI];
    int m_v1 [NI];
    int m_a0 [NI];
    int m_a1 [NI];
    int m_next [NI];
    int m_own [NI];
    int m_pref [NI];
    int m_cnt [NI];

    task automatic chk(input string nm, input int i, input int got, input int want);
        n_tot++;
        if (got == want) n_pass++;
        else $display("FAIL inst%0d %s got %0d want %0d at %0t", i, nm, got, want, $time);
    endtask

    task automatic issue(input int i, output int ang, output int vld);
        if (m_next[i] < n_of(i)) begin
            ang = (m_next[i] * s_of(i)) % 256;
            vld = 1;
            m_next[i]++;
        end else begin
            ang = 0;
            vld = 0;
        end
    endtask

    task automatic model_step(input int i);
        int pb, pd, pown, pv0, pv1, g;
        bit e0, e1;
        if (!reset_n) begin
            m_busy[i] = 0; m_done[i] = 0; m_sw0[i] = 0; m_sw1[i] = 0;
            m_v0[i] = 0; m_v1[i] = 0; m_a0[i] = 0; m_a1[i] = 0;
            m_next[i] = 0; m_own[i] = -1; m_pref[i] = 0; m_cnt[i] = 0;
            return;
        end
        pb = m_busy[i]; pd = m_done[i]; pown = m_own[i]; pv0 = m_v0[i]; pv1 = m_v1[i];
        m_done[i] = 0; m_sw0[i] = 0; m_sw1[i] = 0;
        if (pb == 0) begin
            if (st[i] && pd == 0) begin
                m_busy[i] = 1; m_next[i] = 0; m_own[i] = -1; m_pref[i] = 0; m_cnt[i] = 0;
                m_a0[i] = 0; m_a1[i] = 0; m_v0[i] = 0; m_v1[i] = 0;
            end
        end else begin
            if (na0[i]) issue(i, m_a0[i], m_v0[i]);
            if (na1[i]) issue(i, m_a1[i], m_v1[i]);
            if (pown < 0) begin
                e0 = fw0[i] && (pv0 != 0);
                e1 = fw1[i] && (pv1 != 0);
                if (e0 && e1) g = m_pref[i];
                else if (e0) g = 0;
                else if (e1) g = 1;
                else g = -1;
                if (g >= 0) begin
                    m_own[i] = g;
                    m_pref[i] = 1 - g;
                    if (g == 0) m_sw0[i] = 1; else m_sw1[i] = 1;
                end
            end else if ((pown == 0 && sd0[i]) || (pown == 1 && sd1[i])) begin
                m_own[i] = -1;
                m_cnt[i]++;
                if (m_cnt[i] == n_of(i)) begin
                    m_busy[i] = 0;
                    m_done[i] = 1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) model_step(i);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < NI; i++) begin
                    chk("busy", i, int'(busy[i]), m_busy[i]);
                    chk("sc_reset_n", i, int'(scr[i]), m_busy[i]);
                    chk("done", i, int'(done[i]), m_done[i]);
                    chk("swap_0", i, int'(sw0[i]), m_sw0[i]);
                    chk("swap_1", i, int'(sw1[i]), m_sw1[i]);
                    chk("angle_valid_0", i, int'(av0[i]), m_v0[i]);
                    chk("angle_valid_1", i, int'(av1[i]), m_v1[i]);
                    chk("angle_0", i, int'(an0[i]), m_a0[i]);
                    chk("angle_1", i, int'(an1[i]), m_a1[i]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < NI; i++) begin
            st[i] = 0; na0[i] = 0; na1[i] = 0; fw0[i] = 0; fw1[i] = 0; sd0[i] = 0; sd1[i] = 0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        tick();
        tick();
        chk_en = 1'b1;
        chk("lit_rst_busy", 0, int'(busy[0]), 0);
        chk("lit_rst_sc", 0, int'(scr[0]), 0);
        chk("lit_rst_angle_1", 0, int'(an1[0]), 0);
        reset_n = 1'b1;
        tick();

        // Instance 0: 3 angles, step 60
        st[0] = 1; tick(); st[0] = 0;
        chk("lit_busy", 0, int'(busy[0]), 1);
        chk("lit_sc", 0, int'(scr[0]), 1);
        na0[0] = 1; na1[0] = 1; tick(); na0[0] = 0; na1[0] = 0;
        chk("lit_a0_first", 0, int'(an0[0]), 0);
        chk("lit_a1_first", 0, int'(an1[0]), 60);
        chk("lit_v0_first", 0, int'(av0[0]), 1);
        chk("lit_v1_first", 0, int'(av1[0]), 1);
        fw0[0] = 1; fw1[0] = 1; tick();
        chk("lit_swap0_tie", 0, int'(sw0[0]), 1);
        chk("lit_swap1_tie", 0, int'(sw1[0]), 0);
        sd1[0] = 1; tick(); sd1[0] = 0;
        chk("lit_nonowner_sd", 0, int'(sw1[0]), 0);
        sd0[0] = 1; fw0[0] = 0; tick(); sd0[0] = 0;
        chk("lit_no_swap_yet", 0, int'(sw1[0]), 0);
        st[0] = 1; tick(); st[0] = 0;
        chk("lit_swap1_after_sd", 0, int'(sw1[0]), 1);
        chk("lit_busy_start_ignored", 0, int'(busy[0]), 1);
        na0[0] = 1; tick(); na0[0] = 0;
        chk("lit_a0_third", 0, int'(an0[0]), 120);
        chk("lit_v0_third", 0, int'(av0[0]), 1);
        sd1[0] = 1; fw1[0] = 0; tick(); sd1[0] = 0;
        fw0[0] = 1; tick();
        chk("lit_swap0_second", 0, int'(sw0[0]), 1);
        na1[0] = 1; tick(); na1[0] = 0;
        chk("lit_v1_exhausted", 0, int'(av1[0]), 0);
        chk("lit_a1_exhausted", 0, int'(an1[0]), 0);
        fw1[0] = 1; tick();
        chk("lit_no_swap1_invalid", 0, int'(sw1[0]), 0);
        sd0[0] = 1; tick(); sd0[0] = 0;
        chk("lit_done", 0, int'(done[0]), 1);
        chk("lit_busy_drop", 0, int'(busy[0]), 0);
        chk("lit_sc_drop", 0, int'(scr[0]), 0);
        st[0] = 1; tick(); st[0] = 0;
        chk("lit_done_once", 0, int'(done[0]), 0);
        chk("lit_start_in_done", 0, int'(busy[0]), 0);
        tick();
        chk("lit_idle_after_done", 0, int'(busy[0]), 0);
        clr();

        // Instance 1: 4 angles, step 100, wraps at 256
        st[1] = 1; tick(); st[1] = 0;
        na0[1] = 1; tick(); na0[1] = 0;
        chk("lit_w_a0", 1, int'(an0[1]), 0);
        na1[1] = 1; tick(); na1[1] = 0;
        chk("lit_w_a1", 1, int'(an1[1]), 100);
        na0[1] = 1; na1[1] = 1; tick(); na0[1] = 0; na1[1] = 0;
        chk("lit_w_a0_200", 1, int'(an0[1]), 200);
        chk("lit_w_a1_44", 1, int'(an1[1]), 44);
        chk("lit_w_v1_44", 1, int'(av1[1]), 1);
        na0[1] = 1; tick(); na0[1] = 0;
        chk("lit_w_v0_end", 1, int'(av0[1]), 0);

        // Instance 2: single angle, bank 1 gets an invalid ticket
        st[2] = 1; tick(); st[2] = 0;
        na0[2] = 1; na1[2] = 1; tick(); na0[2] = 0; na1[2] = 0;
        chk("lit_n1_v0", 2, int'(av0[2]), 1);
        chk("lit_n1_v1", 2, int'(av1[2]), 0);
        fw0[2] = 1; fw1[2] = 1; tick();
        chk("lit_n1_swap0", 2, int'(sw0[2]), 1);
        tick();
        sd0[2] = 1; tick(); sd0[2] = 0;
        chk("lit_n1_done", 2, int'(done[2]), 1);
        clr();

        // Mid-sweep reset on instance 1
        chk("lit_pre_rst_busy", 1, int'(busy[1]), 1);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("lit_mid_rst_busy", 1, int'(busy[1]), 0);
        chk("lit_mid_rst_sc", 1, int'(scr[1]), 0);
        chk("lit_mid_rst_a0", 1, int'(an0[1]), 0);
        chk("lit_mid_rst_v1", 1, int'(av1[1]), 0);
        tick(); tick(); tick();
        chk("lit_no_done_after_rst", 1, int'(done[1]), 0);
        st[1] = 1; tick(); st[1] = 0;
        chk("lit_restart_busy", 1, int'(busy[1]), 1);
        na0[1] = 1; tick(); na0[1] = 0;
        chk("lit_restart_a0", 1, int'(an0[1]), 0);
        chk("lit_restart_v0", 1, int'(av0[1]), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/nabp_swap_control.md
NABP_SWAP_CONTROL -- requirements
Module: nabp_swap_control

Interface
REQ-001 The block SHALL have parameter ANGLE_LEN, default 8, meaning angle output width (matches kAngleLength).
REQ-002 The block SHALL have parameter NUM_ANGLES, default 180, meaning projection angles per sweep (1..2^ANGLE_LEN).
REQ-003 The block SHALL have parameter ANGLE_STEP, default 1, meaning angle increment between consecutive issued angles.
REQ-004 The block SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, one-cycle pulse that begins a sweep.
REQ-007 The block SHALL have port busy, output, 1, high from the cycle after an accepted start until the sweep completes.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when the sweep completes.
REQ-009 The block SHALL have port sc_reset_n, output, 1, synchronous reset for both downstream state controls, equal to registered busy.
REQ-010 The block SHALL have ports next_angle_0 and next_angle_1, input, 1 each, angle request from bank 0/1 state control.
REQ-011 The block SHALL have ports fill_waiting_0 and fill_waiting_1, input, 1 each, bank has finished filling and awaits swap.
REQ-012 The block SHALL have ports shift_done_0 and shift_done_1, input, 1 each, one-cycle pulse when bank finishes shifting.
REQ-013 The block SHALL have ports angle_0 and angle_1, output, ANGLE_LEN each, angle assigned to bank 0/1.
REQ-014 The block SHALL have ports angle_valid_0 and angle_valid_1, output, 1 each, high when the assigned angle is a real sweep angle.
REQ-015 The block SHALL have ports swap_0 and swap_1, output, 1 each, one-cycle pulse granting bank 0/1 the shifter.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, and DONE: IDLE->RUN on start; RUN->DONE when completed count reaches NUM_ANGLES; DONE->IDLE unconditionally after one cycle.
REQ-017 In IDLE and DONE the block SHALL hold busy=0 and sc_reset_n=0; in RUN it SHALL hold busy=1 and sc_reset_n=1.
REQ-018 The block SHALL ignore start outside IDLE.
REQ-019 The block SHALL maintain an issue index k (width clog2(NUM_ANGLES+1)), cleared on start; the issued angle value SHALL equal k*ANGLE_STEP truncated to ANGLE_LEN bits (wrap-around permitted).
REQ-020 When next_angle_b is high in RUN at cycle t, angle_b SHALL hold the new value from cycle t+1 until the next request by that bank.
REQ-021 For any bank request with k<NUM_ANGLES, the block SHALL set angle_valid_b=1 and k<=k+1.
REQ-022 For any bank request with k==NUM_ANGLES, the block SHALL set angle_valid_b=0 and angle_b=0.
REQ-023 On simultaneous requests, bank 0 SHALL receive index k and bank 1 SHALL receive index k+1 if k+1<NUM_ANGLES (otherwise bank 1 is invalid), and k SHALL advance by the number of valid grants.
REQ-024 The block SHALL keep a shifter owner register (none/0/1), reset to none on start.
REQ-025 swap_b SHALL pulse at t+1 when, at t, owner==none, fill_waiting_b=1, angle_valid_b=1, and bank b is chosen by arbitration; owner SHALL become b in the same cycle as the pulse.
REQ-026 When both banks are eligible, arbitration SHALL grant the bank other than the last one swapped, with bank 0 first after start.
REQ-027 shift_done_b from the owner SHALL set owner=none at t+1 and increment the completed count.
REQ-028 shift_done from a non-owner SHALL be ignored.
REQ-029 swap_b SHALL never pulse in two consecutive cycles, and never while owner!=none.
REQ-030 done SHALL pulse for one cycle in the cycle the FSM enters DONE; NUM_ANGLES=1 SHALL complete correctly with bank 1 receiving an invalid angle.

Reset
REQ-031 While reset_n=0 at a clock edge, the block SHALL set state=IDLE, k=0, completed=0, and owner=none.
REQ-032 While reset_n=0 at a clock edge, the block SHALL drive busy, done, sc_reset_n, swap_0, swap_1, angle_valid_0, and angle_valid_1 to 0, and angle_0 and angle_1 to 0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.

Verification
REQ-034 With NUM_ANGLES=3 and ANGLE_STEP=60, a start pulse followed by simultaneous next_angle_0/1 SHALL produce angle_0=0 and angle_1=60, both valid, one cycle later.
REQ-035 With both banks fill_waiting and owner none, the block SHALL give swap_0 only; shift_done_0 SHALL then lead to swap_1 two cycles later if bank 1 is still waiting.
REQ-036 In the third request round, a request by bank 0 SHALL get angle 120 valid, and the next bank-1 request SHALL get angle_valid_1=0 with no swap_1 issued.
REQ-037 After 3 owner shift_done pulses, the block SHALL pulse done once and drop busy and sc_reset_n the next cycle; a start while busy SHALL cause no change.
REQ-038 With ANGLE_LEN=8, ANGLE_STEP=100, and NUM_ANGLES=4, the block SHALL issue angles 0, 100, 200, and 44 (wrap-around).
REQ-039 With reset_n=0 asserted mid-RUN for one cycle, all outputs SHALL be 0 next cycle, state SHALL be IDLE, and no done pulse SHALL occur.
